// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the instruction-port, data-port and physical
//                memory-port signals around mem_arbiter.
//                slave  modport : arbiter view (takes requests, drives pmem_*)
//                master modport : environment view (core stages + memory)
//  Ports       : i_read/i_address/i_rdata/i_resp          - fetch port
//                d_read/d_write/d_address/d_wdata/
//                d_byte_enable/d_rdata/d_resp              - data port
//                pmem_read/pmem_write/pmem_address/
//                pmem_wdata/pmem_byte_enable/pmem_rdata/
//                pmem_resp                                 - physical port
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = 2
);
    // instruction port
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;
    // data port
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_byte_enable;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;
    // physical memory port
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic [MASK_W-1:0] pmem_byte_enable;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata, d_byte_enable,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata, d_byte_enable,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        output pmem_rdata, pmem_resp
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port to one-port memory arbiter. Serialises instruction
//                fetch reads and data reads/writes onto one physical memory
//                port, one transaction in flight, alternating on conflict.
//  Ports       : clk   - clock, all state on rising edge
//                reset - asynchronous active-high reset
//                bus   - mem_arbiter_if.slave (fetch, data and pmem ports)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MASK_W  = 2,
    parameter bit D_FIRST = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SERVE_I = 2'd1;
    localparam logic [1:0] c_ST_SERVE_D = 2'd2;

    localparam logic c_GRANT_I = 1'b0;
    localparam logic c_GRANT_D = 1'b1;
    // last_grant starts on the port that should LOSE the first conflict
    localparam logic c_LAST_RESET = D_FIRST ? c_GRANT_I : c_GRANT_D;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_last_grant;

    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [DATA_W-1:0] r_pmem_wdata;
    logic [MASK_W-1:0] r_pmem_byte_enable;

    logic              w_idle;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_done;

    assign w_idle  = (r_state == c_ST_IDLE);
    assign w_d_req = bus.d_read | bus.d_write;

    // On conflict the port that did not win last time is granted.
    assign w_grant_d = w_idle & w_d_req &
                       (~bus.i_read | (r_last_grant == c_GRANT_I));
    assign w_grant_i = w_idle & bus.i_read &
                       (~w_d_req | (r_last_grant == c_GRANT_D));

    // pmem_resp only counts while a transaction is outstanding
    assign w_done = ~w_idle & bus.pmem_resp;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_d) begin
                    w_next_state = c_ST_SERVE_D;
                end else if (w_grant_i) begin
                    w_next_state = c_ST_SERVE_I;
                end
            end
            c_ST_SERVE_I,
            c_ST_SERVE_D: begin
                if (bus.pmem_resp) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: completion is routed combinationally to the owner
    // ------------------------------------------------------------------
    always_comb begin
        bus.i_resp  = 1'b0;
        bus.i_rdata = {DATA_W{1'b0}};
        bus.d_resp  = 1'b0;
        bus.d_rdata = {DATA_W{1'b0}};
        case (r_state)
            c_ST_SERVE_I: begin
                if (bus.pmem_resp) begin
                    bus.i_resp  = 1'b1;
                    bus.i_rdata = bus.pmem_rdata;
                end
            end
            c_ST_SERVE_D: begin
                if (bus.pmem_resp) begin
                    bus.d_resp  = 1'b1;
                    bus.d_rdata = bus.pmem_rdata;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Physical port registers: captured on the grant edge and held for
    // the whole transaction, so requestor changes mid-flight are ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pmem_read        <= 1'b0;
            r_pmem_write       <= 1'b0;
            r_pmem_address     <= {ADDR_W{1'b0}};
            r_pmem_wdata       <= {DATA_W{1'b0}};
            r_pmem_byte_enable <= {MASK_W{1'b0}};
            r_last_grant       <= c_LAST_RESET;
        end else if (w_grant_d) begin
            // write has priority when both data strobes are high
            r_pmem_read        <= bus.d_read & ~bus.d_write;
            r_pmem_write       <= bus.d_write;
            r_pmem_address     <= bus.d_address;
            r_pmem_wdata       <= bus.d_wdata;
            r_pmem_byte_enable <= bus.d_byte_enable;
            r_last_grant       <= c_GRANT_D;
        end else if (w_grant_i) begin
            r_pmem_read        <= 1'b1;
            r_pmem_write       <= 1'b0;
            r_pmem_address     <= bus.i_address;
            r_pmem_wdata       <= {DATA_W{1'b0}};
            r_pmem_byte_enable <= {MASK_W{1'b0}};
            r_last_grant       <= c_GRANT_I;
        end else if (w_done) begin
            r_pmem_read        <= 1'b0;
            r_pmem_write       <= 1'b0;
        end
    end

    assign bus.pmem_read        = r_pmem_read;
    assign bus.pmem_write       = r_pmem_write;
    assign bus.pmem_address     = r_pmem_address;
    assign bus.pmem_wdata       = r_pmem_wdata;
    assign bus.pmem_byte_enable = r_pmem_byte_enable;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed vector table,
//                hand-written multi-cycle sequences, and a randomized phase
//                against a word-level memory reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic reset;

    mem_arbiter_if ifc ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MASK_W(2), .D_FIRST(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Memory model. Manual mode: bench drives resp/rdata directly.
    // Auto mode: answers each strobe after a random 0..mem_lat_max cycles.
    // pattern=1 returns ~address on reads; otherwise a 16-word array.
    // ------------------------------------------------------------------
    logic        mem_en = 1'b0;
    logic        pattern = 1'b1;
    int          mem_lat_max = 0;
    logic        man_resp = 1'b0;
    logic [15:0] man_rdata = 16'h0;
    logic        m_resp;
    logic [15:0] m_rdata;
    logic [15:0] phys [16];
    logic [15:0] refm [16];

    assign ifc.pmem_resp  = mem_en ? m_resp  : man_resp;
    assign ifc.pmem_rdata = mem_en ? m_rdata : man_rdata;

    initial begin
        int cnt;
        int lat;
        m_resp = 1'b0; m_rdata = 16'h0; cnt = 0; lat = 0;
        forever begin
            @(negedge clk);
            if (!mem_en || m_resp) begin
                m_resp = 1'b0; m_rdata = 16'h0; cnt = 0;
                lat = $urandom_range(0, mem_lat_max);
            end else if (ifc.pmem_read || ifc.pmem_write) begin
                if (cnt >= lat) begin
                    m_resp = 1'b1;
                    if (pattern) begin
                        m_rdata = ifc.pmem_read ? ~ifc.pmem_address : 16'h0;
                    end else if (ifc.pmem_write) begin
                        if (ifc.pmem_byte_enable[0]) phys[ifc.pmem_address[3:0]][7:0]  = ifc.pmem_wdata[7:0];
                        if (ifc.pmem_byte_enable[1]) phys[ifc.pmem_address[3:0]][15:8] = ifc.pmem_wdata[15:8];
                        m_rdata = 16'h0;
                    end else begin
                        m_rdata = phys[ifc.pmem_address[3:0]];
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    // response monitor for the randomized phase
    logic mon_en = 1'b0;
    int   i_cnt = 0;
    int   d_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (ifc.i_resp) i_cnt++;
                if (ifc.d_resp) d_cnt++;
                check("resp_exclusive", {31'b0, ifc.i_resp & ifc.d_resp}, 32'd0);
            end
        end
    end

    typedef struct {
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [15:0] dwd;
        logic [1:0]  dbe;
        logic        exp_d;
        logic        exp_rd;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [1:0]  exp_be;
    } vec_t;

    vec_t vecs [9];

    task automatic clear_reqs();
        ifc.i_read = 1'b0; ifc.i_address = 16'h0;
        ifc.d_read = 1'b0; ifc.d_write = 1'b0; ifc.d_address = 16'h0;
        ifc.d_wdata = 16'h0; ifc.d_byte_enable = 2'b00;
    endtask

    localparam int NI = 40;
    localparam int ND = 40;

    initial begin
        // ir ia       dr dw da       dwd      dbe    exp_d rd wr addr    wdata    be
        vecs[0] = '{1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 1, 0, 16'h0040, 16'h0000, 2'b00};
        vecs[1] = '{0, 16'h0000, 0, 1, 16'h0100, 16'hBEEF, 2'b10, 1, 0, 1, 16'h0100, 16'hBEEF, 2'b10};
        vecs[2] = '{1, 16'h0200, 1, 0, 16'h0300, 16'h7777, 2'b11, 0, 1, 0, 16'h0200, 16'h0000, 2'b00};
        vecs[3] = '{1, 16'h0210, 0, 1, 16'h0310, 16'h5A5A, 2'b11, 1, 0, 1, 16'h0310, 16'h5A5A, 2'b11};
        vecs[4] = '{0, 16'h0000, 1, 1, 16'h0400, 16'h1111, 2'b01, 1, 0, 1, 16'h0400, 16'h1111, 2'b01};
        vecs[5] = '{1, 16'h0220, 1, 0, 16'h0500, 16'h2222, 2'b10, 0, 1, 0, 16'h0220, 16'h0000, 2'b00};
        vecs[6] = '{0, 16'h0000, 1, 0, 16'h0600, 16'hCAFE, 2'b11, 1, 1, 0, 16'h0600, 16'hCAFE, 2'b11};
        vecs[7] = '{1, 16'h0230, 1, 1, 16'h0700, 16'h9999, 2'b01, 0, 1, 0, 16'h0230, 16'h0000, 2'b00};
        vecs[8] = '{1, 16'h0240, 1, 1, 16'h0700, 16'h3333, 2'b10, 1, 0, 1, 16'h0700, 16'h3333, 2'b10};

        reset = 1'b1;
        clear_reqs();

        // ---------------- reset state and reset mid-transaction -------
        repeat (2) @(negedge clk);
        #1;
        check("rst_pmem_read",  {31'b0, ifc.pmem_read},  32'd0);
        check("rst_pmem_write", {31'b0, ifc.pmem_write}, 32'd0);
        check("rst_pmem_addr",  {16'b0, ifc.pmem_address}, 32'd0);
        check("rst_pmem_wdata", {16'b0, ifc.pmem_wdata}, 32'd0);
        check("rst_pmem_be",    {30'b0, ifc.pmem_byte_enable}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        ifc.d_read = 1'b1; ifc.d_address = 16'h0AAA;
        @(negedge clk); #1;
        check("rst_pre_read", {31'b0, ifc.pmem_read}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_read",  {31'b0, ifc.pmem_read},  32'd0);
        check("rst_async_write", {31'b0, ifc.pmem_write}, 32'd0);
        clear_reqs();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        man_resp = 1'b1; man_rdata = 16'hDEAD;
        #1;
        check("rst_late_i_resp", {31'b0, ifc.i_resp}, 32'd0);
        check("rst_late_d_resp", {31'b0, ifc.d_resp}, 32'd0);
        check("rst_late_d_rdata", {16'b0, ifc.d_rdata}, 32'd0);
        @(negedge clk);
        man_resp = 1'b0; man_rdata = 16'h0;
        #1;
        check("rst_after_idle", {31'b0, ifc.pmem_read | ifc.pmem_write}, 32'd0);

        // ---------------- vector table, zero-wait memory --------------
        pattern = 1'b1; mem_lat_max = 0; mem_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            logic [15:0] exp_rdata;
            @(negedge clk);
            ifc.i_read = vecs[k].ir; ifc.i_address = vecs[k].ia;
            ifc.d_read = vecs[k].dr; ifc.d_write = vecs[k].dw; ifc.d_address = vecs[k].da;
            ifc.d_wdata = vecs[k].dwd; ifc.d_byte_enable = vecs[k].dbe;
            @(negedge clk); #1;
            exp_rdata = vecs[k].exp_rd ? ~vecs[k].exp_addr : 16'h0;
            check($sformatf("v%0d_read", k),  {31'b0, ifc.pmem_read},  {31'b0, vecs[k].exp_rd});
            check($sformatf("v%0d_write", k), {31'b0, ifc.pmem_write}, {31'b0, vecs[k].exp_wr});
            check($sformatf("v%0d_addr", k),  {16'b0, ifc.pmem_address}, {16'b0, vecs[k].exp_addr});
            check($sformatf("v%0d_wdata", k), {16'b0, ifc.pmem_wdata},   {16'b0, vecs[k].exp_wdata});
            check($sformatf("v%0d_be", k),    {30'b0, ifc.pmem_byte_enable}, {30'b0, vecs[k].exp_be});
            check($sformatf("v%0d_i_resp", k), {31'b0, ifc.i_resp}, {31'b0, ~vecs[k].exp_d});
            check($sformatf("v%0d_d_resp", k), {31'b0, ifc.d_resp}, {31'b0, vecs[k].exp_d});
            check($sformatf("v%0d_rdata", k),
                  {16'b0, (vecs[k].exp_d ? ifc.d_rdata : ifc.i_rdata)}, {16'b0, exp_rdata});
            clear_reqs();
            @(negedge clk); #1;
            check($sformatf("v%0d_idle", k), {31'b0, ifc.pmem_read | ifc.pmem_write}, 32'd0);
        end
        @(negedge clk);
        mem_en = 1'b0;

        // ---------------- lone fetch, 3-cycle memory, address change --
        @(negedge clk);
        ifc.i_read = 1'b1; ifc.i_address = 16'h0040;
        @(negedge clk); #1;
        check("f_read_n1", {31'b0, ifc.pmem_read}, 32'd1);
        check("f_addr_n1", {16'b0, ifc.pmem_address}, 32'h0040);
        check("f_resp_n1", {31'b0, ifc.i_resp}, 32'd0);
        ifc.i_address = 16'h0042;
        @(negedge clk); #1;
        check("f_addr_hold", {16'b0, ifc.pmem_address}, 32'h0040);
        check("f_resp_n2", {31'b0, ifc.i_resp}, 32'd0);
        check("f_rdata_zero", {16'b0, ifc.i_rdata}, 32'd0);
        @(negedge clk);
        man_resp = 1'b1; man_rdata = 16'h1234;
        #1;
        check("f_addr_n3", {16'b0, ifc.pmem_address}, 32'h0040);
        check("f_i_resp", {31'b0, ifc.i_resp}, 32'd1);
        check("f_i_rdata", {16'b0, ifc.i_rdata}, 32'h1234);
        check("f_d_resp", {31'b0, ifc.d_resp}, 32'd0);
        ifc.i_read = 1'b0;
        @(negedge clk);
        man_resp = 1'b0; man_rdata = 16'h0;
        #1;
        check("f_read_done", {31'b0, ifc.pmem_read}, 32'd0);
        check("f_resp_once", {31'b0, ifc.i_resp}, 32'd0);

        // ---------------- request withdrawn mid-serve, idle resp -------
        @(negedge clk);
        ifc.d_write = 1'b1; ifc.d_address = 16'h0800; ifc.d_wdata = 16'h4444; ifc.d_byte_enable = 2'b11;
        @(negedge clk); #1;
        check("w_write", {31'b0, ifc.pmem_write}, 32'd1);
        clear_reqs();
        @(negedge clk);
        man_resp = 1'b1;
        #1;
        check("w_d_resp", {31'b0, ifc.d_resp}, 32'd1);
        check("w_addr", {16'b0, ifc.pmem_address}, 32'h0800);
        @(negedge clk);
        man_resp = 1'b0;
        @(negedge clk);
        man_resp = 1'b1; man_rdata = 16'h5555;
        #1;
        check("idle_resp_i", {31'b0, ifc.i_resp}, 32'd0);
        check("idle_resp_d", {31'b0, ifc.d_resp}, 32'd0);
        @(negedge clk);
        man_resp = 1'b0; man_rdata = 16'h0;
        #1;
        check("idle_resp_noissue", {31'b0, ifc.pmem_read | ifc.pmem_write}, 32'd0);

        // ---------------- conflict from reset: strict alternation ------
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pattern = 1'b1; mem_lat_max = 0; mem_en = 1'b1;
        ifc.i_read = 1'b1; ifc.i_address = 16'h1000;
        ifc.d_read = 1'b1; ifc.d_address = 16'h2000;
        for (int k = 1; k <= 8; k++) begin
            logic [15:0] ea;
            @(negedge clk); #1;
            if (k % 2 == 1) begin
                ea = (((k - 1) / 2) % 2 == 0) ? 16'h2000 : 16'h1000;
                check($sformatf("c%0d_strobe", k), {31'b0, ifc.pmem_read}, 32'd1);
                check($sformatf("c%0d_addr", k), {16'b0, ifc.pmem_address}, {16'b0, ea});
                check($sformatf("c%0d_d_resp", k), {31'b0, ifc.d_resp}, {31'b0, ea == 16'h2000});
                check($sformatf("c%0d_i_resp", k), {31'b0, ifc.i_resp}, {31'b0, ea == 16'h1000});
            end else begin
                check($sformatf("c%0d_gap", k), {31'b0, ifc.pmem_read}, 32'd0);
            end
        end
        clear_reqs();
        repeat (3) @(negedge clk);

        // ---------------- randomized traffic vs. memory reference -------
        for (int a = 0; a < 16; a++) begin
            phys[a] = 16'($urandom);
            refm[a] = phys[a];
        end
        pattern = 1'b0; mem_lat_max = 3;
        i_cnt = 0; d_cnt = 0;
        @(negedge clk);
        mon_en = 1'b1;
        fork
            begin : p_fetch
                for (int n = 0; n < NI; n++) begin
                    logic [15:0] a;
                    logic got;
                    a = 16'($urandom_range(0, 15));
                    ifc.i_address = a; ifc.i_read = 1'b1;
                    got = 1'b0;
                    for (int t = 0; t < 60 && !got; t++) begin
                        @(negedge clk); #1;
                        if (ifc.i_resp) got = 1'b1;
                    end
                    check("rnd_i_timeout", {31'b0, got}, 32'd1);
                    check("rnd_i_rdata", {16'b0, ifc.i_rdata}, {16'b0, refm[a[3:0]]});
                    ifc.i_read = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin : p_data
                for (int n = 0; n < ND; n++) begin
                    logic [15:0] a;
                    logic [15:0] wd;
                    logic [1:0]  be;
                    int          op;
                    logic        got;
                    a  = 16'($urandom_range(0, 15));
                    wd = 16'($urandom);
                    be = 2'($urandom_range(0, 3));
                    op = $urandom_range(0, 2);
                    ifc.d_address = a; ifc.d_wdata = wd; ifc.d_byte_enable = be;
                    ifc.d_read = (op != 1); ifc.d_write = (op != 0);
                    got = 1'b0;
                    for (int t = 0; t < 60 && !got; t++) begin
                        @(negedge clk); #1;
                        if (ifc.d_resp) got = 1'b1;
                    end
                    check("rnd_d_timeout", {31'b0, got}, 32'd1);
                    if (op != 0) begin
                        if (be[0]) refm[a[3:0]][7:0]  = wd[7:0];
                        if (be[1]) refm[a[3:0]][15:8] = wd[15:8];
                    end else begin
                        check("rnd_d_rdata", {16'b0, ifc.d_rdata}, {16'b0, refm[a[3:0]]});
                    end
                    ifc.d_read = 1'b0; ifc.d_write = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check("rnd_i_count", i_cnt, NI);
        check("rnd_d_count", d_cnt, ND);
        for (int a = 0; a < 16; a++) begin
            check($sformatf("rnd_mem%0d", a), {16'b0, phys[a]}, {16'b0, refm[a]});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
